// File: rtl/rv_iter_alu.sv
// Multi-cycle RV32I ALU with an iterative shifter and valid/ready handshakes.
// Define RV_ITER_ALU_MUL_EN to add the shift-add multiplier (op 15).
module rv_iter_alu #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] rsa_i,
   input  logic [XLEN-1:0] rsb_imm_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] dout_o,
   output logic            busy_o
);

   localparam int SW = $clog2(XLEN);
   localparam int CW = SW + 1;
   localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef RV_ITER_ALU_MUL_EN
   localparam logic [1:0] S_MUL   = 2'd2;
`endif
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]      state;
   logic [XLEN-1:0] sh_q;
   logic [XLEN-1:0] dout_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      kind_q;

   logic [SW-1:0]   shamt;
   logic            is_shift;
   logic [XLEN-1:0] res;
   logic [CW-1:0]   step;
   logic [XLEN-1:0] sh_nx;

`ifdef RV_ITER_ALU_MUL_EN
   logic [XLEN-1:0] mb_q;
   logic [XLEN-1:0] acc_q;
   logic [XLEN-1:0] acc_nx;

   assign acc_nx = acc_q + (mb_q[0] ? sh_q : '0);
`endif

   assign ready_o  = (state == S_IDLE);
   assign busy_o   = (state != S_IDLE);
   assign valid_o  = (state == S_DONE);
   assign dout_o   = dout_q;
   assign shamt    = rsb_imm_i[SW-1:0];
   assign is_shift = (op_i == 4'd5) || (op_i == 4'd6) || (op_i == 4'd7);

   always_comb begin
      res = '0;
      case (op_i)
         4'd0:  res = rsa_i + rsb_imm_i;
         4'd1:  res = rsa_i - rsb_imm_i;
         4'd2:  res = rsa_i & rsb_imm_i;
         4'd3:  res = rsa_i | rsb_imm_i;
         4'd4:  res = rsa_i ^ rsb_imm_i;
         // a shift only finishes here when its amount is zero
         4'd5, 4'd6, 4'd7: res = rsa_i;
         4'd8:  res = {{(XLEN-1){1'b0}}, rsa_i == rsb_imm_i};
         4'd9:  res = {{(XLEN-1){1'b0}}, rsa_i != rsb_imm_i};
         4'd10: res = {{(XLEN-1){1'b0}},
                       $signed(rsa_i) < $signed(rsb_imm_i)};
         4'd11: res = {{(XLEN-1){1'b0}},
                       $signed(rsa_i) >= $signed(rsb_imm_i)};
         4'd12: res = {{(XLEN-1){1'b0}}, rsa_i < rsb_imm_i};
         4'd13: res = {{(XLEN-1){1'b0}}, rsa_i >= rsb_imm_i};
         4'd14: res = rsb_imm_i;
         default: res = '0;
      endcase
   end

   always_comb begin
      step  = (cnt_q < STEP) ? cnt_q : STEP;
      sh_nx = sh_q;
      case (kind_q)
         2'b01:   sh_nx = sh_q << step;
         2'b10:   sh_nx = sh_q >> step;
         default: sh_nx = XLEN'($signed(sh_q) >>> step);
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_IDLE;
         sh_q   <= '0;
         dout_q <= '0;
         cnt_q  <= '0;
         kind_q <= '0;
`ifdef RV_ITER_ALU_MUL_EN
         mb_q   <= '0;
         acc_q  <= '0;
`endif
      end else if (flush_i) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  if (is_shift && (shamt != '0)) begin
                     state  <= S_SHIFT;
                     sh_q   <= rsa_i;
                     cnt_q  <= CW'(shamt);
                     kind_q <= op_i[1:0];
                  end
`ifdef RV_ITER_ALU_MUL_EN
                  else if (op_i == 4'd15) begin
                     state <= S_MUL;
                     sh_q  <= rsa_i;
                     mb_q  <= rsb_imm_i;
                     acc_q <= '0;
                     cnt_q <= CW'(XLEN);
                  end
`endif
                  else begin
                     state  <= S_DONE;
                     dout_q <= res;
                  end
               end
            end
            S_SHIFT: begin
               sh_q  <= sh_nx;
               cnt_q <= cnt_q - step;
               if (cnt_q == step) begin
                  state  <= S_DONE;
                  dout_q <= sh_nx;
               end
            end
`ifdef RV_ITER_ALU_MUL_EN
            S_MUL: begin
               acc_q <= acc_nx;
               sh_q  <= sh_q << 1;
               mb_q  <= mb_q >> 1;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state  <= S_DONE;
                  dout_q <= acc_nx;
               end
            end
`endif
            S_DONE: begin
               if (ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_iter_alu.sv
// Scoreboard bench for rv_iter_alu: directed vectors, queued expectations,
// latency and hold checks, flush and mid-operation reset.
module tb_rv_iter_alu;

   parameter int XLEN       = 32;
   parameter int SHIFT_STEP = 1;

   logic            clk;
   logic            rst_ni;
   logic            flush_i;
   logic            valid_i;
   logic            ready_o;
   logic [3:0]      op_i;
   logic [XLEN-1:0] rsa_i;
   logic [XLEN-1:0] rsb_imm_i;
   logic            valid_o;
   logic            ready_i;
   logic [XLEN-1:0] dout_o;
   logic            busy_o;

   typedef struct {
      logic [31:0] d;
      int          lat;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] d;
      int          lat;
   } vec_t;

   exp_t q[$];
   vec_t v[$];

   int compared   = 0;
   int mismatched = 0;
   int ncyc       = 0;
   int acc_n      = 0;
   bit seen       = 0;

   rv_iter_alu #(
      .XLEN       (XLEN),
      .SHIFT_STEP (SHIFT_STEP)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .flush_i   (flush_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .op_i      (op_i),
      .rsa_i     (rsa_i),
      .rsb_imm_i (rsb_imm_i),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .dout_o    (dout_o),
      .busy_o    (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency in cycles from accept to valid_o for a shift by n.
   function automatic int shl(int n);
      return (n == 0) ? 1 : 1 + (n + SHIFT_STEP - 1) / SHIFT_STEP;
   endfunction

   always @(negedge clk) begin
      ncyc++;
      if (rst_ni && valid_o) begin
         if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_valid: valid_o=1 dout=%h, required valid_o=0",
                     dout_o);
         end else begin
            compared++;
            if (dout_o !== q[0].d) begin
               mismatched++;
               $display("FAIL dout: got %h required %h", dout_o, q[0].d);
            end
            compared++;
            if (ready_o !== 1'b0) begin
               mismatched++;
               $display("FAIL ready_in_done: got %b required 0", ready_o);
            end
            if (!seen) begin
               compared++;
               if (ncyc - acc_n != q[0].lat) begin
                  mismatched++;
                  $display("FAIL latency: got %0d required %0d",
                           ncyc - acc_n, q[0].lat);
               end
               seen = 1'b1;
            end
            if (ready_i) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
      if (rst_ni && valid_i && ready_o && !flush_i) acc_n = ncyc;
   end

   task automatic chk(string nm, logic [31:0] got, logic [31:0] req);
      compared++;
      if (got !== req) begin
         mismatched++;
         $display("FAIL %s: got %h required %h", nm, got, req);
      end
   endtask

   task automatic issue(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                        logic [31:0] d, int lat, bit push);
      int n = 0;
      while (!ready_o && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL ready_timeout: got ready_o=0 required 1");
      end
      if (push) q.push_back('{d, lat});
      op_i      = op;
      rsa_i     = a;
      rsb_imm_i = b;
      valid_i   = 1'b1;
      @(posedge clk);
      #1;
      valid_i   = 1'b0;
      op_i      = 4'd1;
      rsa_i     = 32'hA5A5A5A5;
      rsb_imm_i = 32'h5A5A5A5A;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) begin
         compared++;
         mismatched++;
         $display("FAIL drain_timeout: got %0d pending required 0", q.size());
         q.delete();
         seen = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("ready_after", {31'd0, ready_o}, 32'd1);
   endtask

   initial begin
      rst_ni    = 1'b0;
      flush_i   = 1'b0;
      valid_i   = 1'b0;
      ready_i   = 1'b1;
      op_i      = '0;
      rsa_i     = '0;
      rsb_imm_i = '0;
      #1;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_busy",  {31'd0, busy_o},  32'd0);
      chk("rst_dout",  dout_o,           32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

      v.push_back('{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
      v.push_back('{4'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1});
      v.push_back('{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1});
      v.push_back('{4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1});
      v.push_back('{4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
      v.push_back('{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
      v.push_back('{4'd12, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
      v.push_back('{4'd13, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
      v.push_back('{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
      v.push_back('{4'd8,  32'h00000005, 32'h00000005, 32'h00000001, 1});
      v.push_back('{4'd9,  32'h00000005, 32'h00000005, 32'h00000000, 1});
      v.push_back('{4'd14, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1});
      v.push_back('{4'd7,  32'h80000000, 32'h00000024, 32'hF8000000, shl(4)});
      v.push_back('{4'd6,  32'h80000000, 32'h0000003F, 32'h00000001, shl(31)});
      v.push_back('{4'd5,  32'h00000001, 32'h0000001F, 32'h80000000, shl(31)});
      v.push_back('{4'd5,  32'h000000FF, 32'h00000104, 32'h00000FF0, shl(4)});
      v.push_back('{4'd7,  32'h7FFFFFFF, 32'h00000002, 32'h1FFFFFFF, shl(2)});
      v.push_back('{4'd6,  32'hF0000000, 32'h00000005, 32'h07800000, shl(5)});

      foreach (v[i]) begin
         issue(v[i].op, v[i].a, v[i].b, v[i].d, v[i].lat, 1'b1);
         drain();
      end

      // zero-amount shift, result held while the consumer stalls
      ready_i = 1'b0;
      issue(4'd5, 32'h12345678, 32'h00000020, 32'h12345678, 1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, valid_o}, 32'd1);
      ready_i = 1'b1;
      drain();

      issue(4'd6, 32'h80000000, 32'h0000003F, 32'h0, 0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      flush_i   = 1'b1;
      valid_i   = 1'b1;
      op_i      = 4'd0;
      rsa_i     = 32'h1;
      rsb_imm_i = 32'h1;
      @(posedge clk);
      #1;
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush_ready", {31'd0, ready_o}, 32'd1);
      chk("flush_busy",  {31'd0, busy_o},  32'd0);
      chk("flush_valid", {31'd0, valid_o}, 32'd0);
      chk("flush_dout",  dout_o,           32'h12345678);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_idle", {31'd0, ready_o}, 32'd1);

      issue(4'd5, 32'h00000001, 32'h0000001F, 32'h0, 0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      chk("midop_busy", {31'd0, busy_o}, 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("arst_ready", {31'd0, ready_o}, 32'd1);
      chk("arst_valid", {31'd0, valid_o}, 32'd0);
      chk("arst_busy",  {31'd0, busy_o},  32'd0);
      chk("arst_dout",  dout_o,           32'd0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      @(posedge clk);
      #1;

`ifdef RV_ITER_ALU_MUL_EN
      issue(4'd15, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, XLEN + 1, 1'b1);
`else
      issue(4'd15, 32'h0000FFFF, 32'h00010001, 32'h00000000, 1, 1'b1);
`endif
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
